// File: rtl/reg_file.sv
// N x M register file for the ALU datapath: r0 hardwired to zero, two combinational
// read ports with same-cycle write forwarding, a 4-bit flag register and a write counter.

module reg_file_entry #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [M-1:0] wd,
  output logic [M-1:0] q
);
  logic [M-1:0] data_q, data_d;

  always_comb data_d = wen ? wd : data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;
endmodule

module reg_file #(
  parameter int M  = 8,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [M-1:0]  wd,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [M-1:0]  rga,
  output logic [M-1:0]  rgb,
  input  logic          fwe,
  input  logic [3:0]    fin,
  output logic [3:0]    flags,
  output logic [7:0]    wr_cnt
);
  typedef struct packed {
    logic          vld;
    logic [AW-1:0] addr;
    logic [M-1:0]  data;
  } wr_req_t;

  wr_req_t              wr;
  logic [N-1:0][M-1:0]  regs;
  logic [3:0]           flags_q, flags_d;
  logic [7:0]           cnt_q, cnt_d;

  // A write is accepted only for a nonzero address and outside reset; this single
  // qualifier gates storage, forwarding and the counter alike.
  assign wr.vld  = we & (wa != '0) & ~rst;
  assign wr.addr = wa;
  assign wr.data = wd;

  assign regs[0] = '0;

  for (genvar i = 1; i < N; i++) begin : g_reg
    reg_file_entry #(.M(M)) u_entry (
      .clk (clk),
      .rst (rst),
      .wen (wr.vld && (wr.addr == AW'(i))),
      .wd  (wr.data),
      .q   (regs[i])
    );
  end

  always_comb begin
    rga = regs[ra];
    rgb = regs[rb];
    if (wr.vld && (ra == wr.addr)) rga = wr.data;
    if (wr.vld && (rb == wr.addr)) rgb = wr.data;
    if (rst) begin
      rga = '0;
      rgb = '0;
    end
  end

  always_comb begin
    flags_d = fwe ? fin : flags_q;
    cnt_d   = wr.vld ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flags  = flags_q;
  assign wr_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_file;
  localparam int M = 8, N = 8, AW = 3;

  logic          clk = 1'b0;
  logic          rst, we, fwe;
  logic [AW-1:0] wa, ra, rb;
  logic [M-1:0]  wd;
  logic [3:0]    fin;
  logic [M-1:0]  rga, rgb;
  logic [3:0]    flags;
  logic [7:0]    wr_cnt;

  int checks = 0;
  int errors = 0;

  logic [M-1:0] mdl [N];
  logic [3:0]   mflags;
  int           mcnt;

  reg_file #(.M(M), .N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rb(rb),
    .rga(rga), .rgb(rgb), .fwe(fwe), .fin(fin), .flags(flags), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] exp_rd(input logic [AW-1:0] a);
    if (rst) return '0;
    if (we && wa != 0 && a == wa) return wd;
    if (a == 0) return '0;
    return mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl[i] = '0;
    mflags = '0;
    mcnt   = 0;
  endtask

  // One rising edge; the model applies the architectural update with the inputs
  // the DUT saw, then inputs may be changed 1ns later.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (we && wa != 0) begin
        mdl[wa] = wd;
        mcnt    = (mcnt + 1) % 256;
      end
      if (fwe) mflags = fin;
    end
    #1;
  endtask

  task automatic idle();
    we = 0; fwe = 0; wa = 0; wd = 0; fin = 0;
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1;
    model_reset();
    step();
    #2 rst = 0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < N; a++) begin
      ra = AW'(a); rb = AW'(N - 1 - a);
      #2;
      checks++;
      if (rga !== '0 || rgb !== '0) begin
        errors++;
        $display("FAIL reset_read addr=%0d rga=%h rgb=%h want 00", a, rga, rgb);
      end
    end
    checks++;
    if (flags !== 4'b0 || wr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state flags=%b wr_cnt=%0d want 0000/0", flags, wr_cnt);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    we = 1; wa = 3; wd = 8'hA5;
    step();
    we = 0; ra = 3; rb = 3;
    #2;
    checks++;
    if (rga !== 8'hA5 || rgb !== 8'hA5 || wr_cnt !== 8'd1) begin
      errors++;
      $display("FAIL write_read rga=%h rgb=%h cnt=%0d want a5 a5 1", rga, rgb, wr_cnt);
    end
  endtask

  task automatic test_forward_r0();
    logic [7:0] cnt0;
    we = 1; wa = 5; wd = 8'h3C; ra = 5; rb = 5;
    #2;
    checks++;
    if (rga !== 8'h3C || rgb !== 8'h3C) begin
      errors++;
      $display("FAIL forward rga=%h rgb=%h want 3c", rga, rgb);
    end
    step();
    cnt0 = wr_cnt;
    wa = 0; wd = 8'hFF; ra = 0; rb = 0;
    #2;
    checks++;
    if (rga !== 8'h00 || rgb !== 8'h00) begin
      errors++;
      $display("FAIL r0_fwd rga=%h rgb=%h want 00", rga, rgb);
    end
    step();
    we = 0;
    #2;
    checks++;
    if (rga !== 8'h00 || wr_cnt !== cnt0) begin
      errors++;
      $display("FAIL r0_write rga=%h cnt=%0d want 00 %0d", rga, wr_cnt, cnt0);
    end
  endtask

  task automatic test_flags();
    fwe = 1; fin = 4'b1011;
    #2;
    checks++;
    if (flags !== mflags) begin
      errors++;
      $display("FAIL flag_noforward flags=%b want %b", flags, mflags);
    end
    step();
    fwe = 0; fin = 4'b0000;
    #2;
    checks++;
    if (flags !== 4'b1011) begin
      errors++;
      $display("FAIL flag_capture flags=%b want 1011", flags);
    end
    step();
    checks++;
    if (flags !== 4'b1011) begin
      errors++;
      $display("FAIL flag_hold flags=%b want 1011", flags);
    end
  endtask

  task automatic test_async_reset();
    idle();
    we = 1; wa = 2; wd = 8'h11;
    step();
    ra = 2; rb = 2; wd = 8'h77;
    #2;
    checks++;
    if (rga !== 8'h77) begin
      errors++;
      $display("FAIL pre_reset_fwd rga=%h want 77", rga);
    end
    rst = 1;
    model_reset();
    #1;
    checks++;
    if (rga !== 8'h00 || rgb !== 8'h00 || wr_cnt !== 8'd0 || flags !== 4'b0) begin
      errors++;
      $display("FAIL async_reset rga=%h rgb=%h cnt=%0d flags=%b want 0", rga, rgb, wr_cnt, flags);
    end
    step();
    we = 0;
    #2 rst = 0;
    #1;
    checks++;
    if (rga !== 8'h00 || wr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL post_reset rga=%h cnt=%0d want 00 0", rga, wr_cnt);
    end
    we = 1; wa = 2; wd = 8'h5A;
    step();
    we = 0;
    #2;
    checks++;
    if (rga !== 8'h5A || wr_cnt !== 8'd1) begin
      errors++;
      $display("FAIL first_edge_write rga=%h cnt=%0d want 5a 1", rga, wr_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] last;
    do_reset();
    we = 1; wa = 1;
    last = 0;
    for (int i = 0; i < 256; i++) begin
      last = 8'($urandom);
      wd = last;
      step();
    end
    we = 0; ra = 1; rb = 1;
    #2;
    checks++;
    if (wr_cnt !== 8'd0 || rga !== last || rgb !== last) begin
      errors++;
      $display("FAIL wrap cnt=%0d r1=%h/%h want 0 %h", wr_cnt, rga, rgb, last);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we  = 1'($urandom_range(0, 1));
      fwe = 1'($urandom_range(0, 3) == 0);
      wa  = AW'($urandom);
      wd  = 8'($urandom);
      fin = 4'($urandom);
      ra  = (c % 5 == 0) ? wa : AW'($urandom);
      rb  = (c % 7 == 0) ? ra : AW'($urandom);
      #2;
      checks++;
      if ($isunknown({we, fwe})) begin
        errors++;
        $display("FAIL x_enable we=%b fwe=%b want known", we, fwe);
      end
      checks++;
      if (rga !== exp_rd(ra) || rgb !== exp_rd(rb)) begin
        errors++;
        $display("FAIL rand_read c=%0d ra=%0d rb=%0d rga=%h rgb=%h want %h %h",
                 c, ra, rb, rga, rgb, exp_rd(ra), exp_rd(rb));
      end
      checks++;
      if (flags !== mflags || wr_cnt !== 8'(mcnt)) begin
        errors++;
        $display("FAIL rand_state c=%0d flags=%b cnt=%0d want %b %0d",
                 c, flags, wr_cnt, mflags, mcnt);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 1; i < N; i++) begin
      we = 1; wa = AW'(i); wd = 8'(i * 17 + 3); fwe = 1; fin = 4'(i);
      step();
    end
    idle();
    #2;
    for (int i = 0; i < N; i++) begin
      ra = AW'(i); rb = AW'(i);
      #1;
      checks++;
      if (rga !== exp_rd(ra) || rgb !== rga) begin
        errors++;
        $display("FAIL b2b_read addr=%0d rga=%h rgb=%h want %h", i, rga, rgb, exp_rd(ra));
      end
    end
    checks++;
    if (flags !== 4'(N - 1) || wr_cnt !== 8'(mcnt)) begin
      errors++;
      $display("FAIL b2b_state flags=%b cnt=%0d want %b %0d", flags, wr_cnt, 4'(N - 1), mcnt);
    end
  endtask

  initial begin
    rst = 1; ra = 0; rb = 0;
    idle();
    model_reset();
    #12 rst = 0;
    test_reset();
    test_write_read();
    test_forward_r0();
    test_flags();
    test_async_reset();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
